// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible resolution, the timing bundle carried
// through pixel stages, and the position clamp helper.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  // One pixel's worth of timing plus colour, as it travels down the pipeline.
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  // Unsigned saturation to an upper limit.
  function automatic logic [11:0] clamp_pos(input logic [11:0] val, input logic [11:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/draw_rect_stage_if.sv
// Signal bundle between the upstream VGA/PS2 sources, draw_rect_stage and
// the cursor stage. The master side feeds the stage; the slave is the stage.
interface draw_rect_stage_if;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic        pos_valid;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;

  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;

  modport master (
    output xpos_in, ypos_in, pos_valid,
    output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
    input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out,
    input  xpos_out, ypos_out
  );

  modport slave (
    input  xpos_in, ypos_in, pos_valid,
    input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
    output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out,
    output xpos_out, ypos_out
  );
endinterface

// File: rtl/draw_rect_stage_pos_latch.sv
// pos_latch: holds the latest clamped mouse sample and promotes it to the
// active (drawn) position only on a vblnk rising edge, so the rectangle never
// moves mid-frame. A sample arriving on the edge cycle itself is used at once.
module pos_latch
  import vga_pkg::*;
#(
  parameter int RECT_W = 48,
  parameter int RECT_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_xpos,
  input  logic [11:0] i_ypos,
  input  logic        i_pos_valid,
  input  logic        i_vblnk,
  output logic [11:0] o_active_x,
  output logic [11:0] o_active_y
);

  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - RECT_W);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - RECT_H);

  logic [11:0] w_x_clamp;
  logic [11:0] w_y_clamp;
  logic        w_vblnk_rise;
  logic        r_vblnk_d;
  logic [11:0] r_pending_x;
  logic [11:0] r_pending_y;
  logic [11:0] r_active_x;
  logic [11:0] r_active_y;

  assign w_x_clamp    = clamp_pos(i_xpos, X_MAX);
  assign w_y_clamp    = clamp_pos(i_ypos, Y_MAX);
  assign w_vblnk_rise = i_vblnk & ~r_vblnk_d;

  // Delayed vblnk for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vblnk_d <= 1'b0;
    else        r_vblnk_d <= i_vblnk;
  end

  // Pending position: captures every new clamped sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_x <= 12'd0;
      r_pending_y <= 12'd0;
    end else if (i_pos_valid) begin
      r_pending_x <= w_x_clamp;
      r_pending_y <= w_y_clamp;
    end
  end

  // Active position: updated only at the frame boundary; a coincident sample wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_x <= 12'd0;
      r_active_y <= 12'd0;
    end else if (w_vblnk_rise) begin
      if (i_pos_valid) begin
        r_active_x <= w_x_clamp;
        r_active_y <= w_y_clamp;
      end else begin
        r_active_x <= r_pending_x;
        r_active_y <= r_pending_y;
      end
    end
  end

  assign o_active_x = r_active_x;
  assign o_active_y = r_active_y;

endmodule

// File: rtl/draw_rect_stage.sv
// draw_rect_stage: paints a fixed-size rectangle at the frame-stable mouse
// position over the incoming VGA stream, with a 2-cycle pipeline for all
// timing and colour. The active position is also forwarded to the cursor stage.
// Optional macro RECT_BORDER_EN: draw the rectangle outline in white.
module draw_rect_stage
  import vga_pkg::*;
#(
  parameter int          RECT_W     = 48,
  parameter int          RECT_H     = 64,
  parameter logic [11:0] RECT_COLOR = 12'hF80
) (
  input logic         pclk,
  input logic         rst_n,
  draw_rect_stage_if.slave bus
);

  logic [11:0] w_active_x;
  logic [11:0] w_active_y;
  timing_t     w_s0;
  logic [12:0] w_hc;
  logic [12:0] w_vc;
  logic [12:0] w_x_lo;
  logic [12:0] w_y_lo;
  logic [12:0] w_x_end;
  logic [12:0] w_y_end;
  logic        w_hit;
  logic [11:0] w_pix;
  timing_t     w_s2_next;
  timing_t     r_s1;
  timing_t     r_s2;
  logic        r_hit;

  pos_latch #(
    .RECT_W(RECT_W),
    .RECT_H(RECT_H)
  ) u_pos_latch (
    .clk        (pclk),
    .rst_n      (rst_n),
    .i_xpos     (bus.xpos_in),
    .i_ypos     (bus.ypos_in),
    .i_pos_valid(bus.pos_valid),
    .i_vblnk    (bus.vblnk_in),
    .o_active_x (w_active_x),
    .o_active_y (w_active_y)
  );

  assign w_s0 = {bus.hcount_in, bus.hsync_in, bus.hblnk_in,
                 bus.vcount_in, bus.vsync_in, bus.vblnk_in, bus.rgb_in};

  // Bounds are 13 bits so active+size cannot wrap.
  assign w_hc    = {2'b00, bus.hcount_in};
  assign w_vc    = {2'b00, bus.vcount_in};
  assign w_x_lo  = {1'b0, w_active_x};
  assign w_y_lo  = {1'b0, w_active_y};
  assign w_x_end = w_x_lo + 13'(RECT_W);
  assign w_y_end = w_y_lo + 13'(RECT_H);
  assign w_hit   = (w_hc >= w_x_lo) && (w_hc < w_x_end) &&
                   (w_vc >= w_y_lo) && (w_vc < w_y_end);

`ifdef RECT_BORDER_EN
  logic w_edge;
  logic r_edge;

  assign w_edge = (w_hc == w_x_lo) || (w_hc == w_x_end - 13'd1) ||
                  (w_vc == w_y_lo) || (w_vc == w_y_end - 13'd1);

  // Outline flag travels alongside the hit flag through S1.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_edge <= 1'b0;
    else        r_edge <= w_edge;
  end
`endif

  // S1: register timing, background pixel and rectangle hit.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_hit <= 1'b0;
    end else begin
      r_s1  <= w_s0;
      r_hit <= w_hit;
    end
  end

  // Compositing: blanking forces black, otherwise rectangle over background.
  always_comb begin
    w_pix = r_s1.rgb;
    if (r_s1.hblnk || r_s1.vblnk) begin
      w_pix = 12'h000;
    end else if (r_hit) begin
`ifdef RECT_BORDER_EN
      w_pix = r_edge ? 12'hFFF : RECT_COLOR;
`else
      w_pix = RECT_COLOR;
`endif
    end
  end

  // S2 payload: S1 timing with the composited colour.
  always_comb begin
    w_s2_next     = r_s1;
    w_s2_next.rgb = w_pix;
  end

  // S2: output register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_s2 <= '0;
    else        r_s2 <= w_s2_next;
  end

  assign bus.hcount_out = r_s2.hcount;
  assign bus.hsync_out  = r_s2.hsync;
  assign bus.hblnk_out  = r_s2.hblnk;
  assign bus.vcount_out = r_s2.vcount;
  assign bus.vsync_out  = r_s2.vsync;
  assign bus.vblnk_out  = r_s2.vblnk;
  assign bus.rgb_out    = r_s2.rgb;
  assign bus.xpos_out   = w_active_x;
  assign bus.ypos_out   = w_active_y;

endmodule

// File: tb/tb_draw_rect_stage.sv
// Directed testbench for draw_rect_stage: reset, frame latching, rectangle
// painting, clamping, blanking, pipeline latency, coincident samples and
// asynchronous reset. Honours RECT_BORDER_EN for the expected outline colour.
module tb_draw_rect_stage;

  logic pclk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [11:0] COL = 12'hF80;
`ifdef RECT_BORDER_EN
  localparam logic [11:0] EDGE_COL = 12'hFFF;
`else
  localparam logic [11:0] EDGE_COL = 12'hF80;
`endif

  always #5 pclk = ~pclk;

  draw_rect_stage_if bus();

  draw_rect_stage dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_px(input logic [10:0] h, input logic [10:0] v, input logic hs,
                          input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
    bus.hcount_in = h;
    bus.hsync_in  = hs;
    bus.hblnk_in  = hb;
    bus.vcount_in = v;
    bus.vsync_in  = vs;
    bus.vblnk_in  = vb;
    bus.rgb_in    = rgb;
  endtask

  // Visible pixel, checked two cycles after it is presented.
  task automatic pixel(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] rgb, input logic [11:0] exp);
    drive_px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb);
    tick;
    tick;
    check(tag, bus.rgb_out, exp);
  endtask

  task automatic sample(input logic [11:0] x, input logic [11:0] y);
    bus.xpos_in   = x;
    bus.ypos_in   = y;
    bus.pos_valid = 1'b1;
    tick;
    bus.pos_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hcount"}, bus.hcount_out, 0);
    check({tag, "_hsync"},  bus.hsync_out,  0);
    check({tag, "_hblnk"},  bus.hblnk_out,  0);
    check({tag, "_vcount"}, bus.vcount_out, 0);
    check({tag, "_vsync"},  bus.vsync_out,  0);
    check({tag, "_vblnk"},  bus.vblnk_out,  0);
    check({tag, "_rgb"},    bus.rgb_out,    0);
    check({tag, "_xpos"},   bus.xpos_out,   0);
    check({tag, "_ypos"},   bus.ypos_out,   0);
  endtask

  // Timing latency vectors: hcount, hsync, hblnk, vcount, vsync, vblnk, rgb_in, rgb expected.
  logic [10:0] tv_h   [3] = '{11'd5, 11'd1030, 11'd17};
  logic        tv_hs  [3] = '{1'b1, 1'b0, 1'b1};
  logic        tv_hb  [3] = '{1'b0, 1'b1, 1'b0};
  logic [10:0] tv_v   [3] = '{11'd3, 11'd700, 11'd770};
  logic        tv_vs  [3] = '{1'b0, 1'b1, 1'b1};
  logic        tv_vb  [3] = '{1'b0, 1'b0, 1'b1};
  logic [11:0] tv_rgb [3] = '{12'h111, 12'h222, 12'h333};
  logic [11:0] tv_exp [3] = '{12'h111, 12'h000, 12'h000};

  initial begin
    rst_n         = 1'b0;
    bus.xpos_in   = '0;
    bus.ypos_in   = '0;
    bus.pos_valid = 1'b0;
    drive_px(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) tick;
    check_zero("rst_init");
    rst_n = 1'b1;

    // Out of reset the rectangle sits at the origin.
    pixel("origin_inside", 11'd10, 11'd10, 12'h123, COL);
    pixel("origin_outside", 11'd48, 11'd10, 12'h123, 12'h123);

    // New sample mid-frame does not move the rectangle yet.
    sample(12'd100, 12'd200);
    check("xpos_hold", bus.xpos_out, 0);
    check("ypos_hold", bus.ypos_out, 0);
    pixel("no_tear", 11'd100, 11'd200, 12'h0AB, 12'h0AB);

    // Frame boundary.
    bus.vblnk_in = 1'b1;
    tick;
    check("xpos_frame", bus.xpos_out, 100);
    check("ypos_frame", bus.ypos_out, 200);
    bus.vblnk_in = 1'b0;
    tick;

    pixel("px_100_200", 11'd100, 11'd200, 12'h0AB, EDGE_COL);
    pixel("px_147_263", 11'd147, 11'd263, 12'h0AB, EDGE_COL);
    pixel("px_148_200", 11'd148, 11'd200, 12'h0AB, 12'h0AB);
    pixel("px_100_264", 11'd100, 11'd264, 12'h0AB, 12'h0AB);
    pixel("px_99_200",  11'd99,  11'd200, 12'h0AB, 12'h0AB);
    pixel("px_100_230", 11'd100, 11'd230, 12'h0AB, EDGE_COL);
    pixel("px_120_230", 11'd120, 11'd230, 12'h0AB, COL);

    // Horizontal blanking inside the rectangle is black.
    drive_px(11'd120, 11'd230, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0AB);
    tick;
    tick;
    check("hblnk_black", bus.rgb_out, 0);

    // Clamp to the bottom-right limit.
    sample(12'd1020, 12'd760);
    bus.vblnk_in = 1'b1;
    tick;
    check("xpos_clamp", bus.xpos_out, 976);
    check("ypos_clamp", bus.ypos_out, 704);
    bus.vblnk_in = 1'b0;
    tick;
    pixel("px_1023_767", 11'd1023, 11'd767, 12'h456, EDGE_COL);
    pixel("px_975_767",  11'd975,  11'd767, 12'h456, 12'h456);

    // Every timing output is the input delayed by exactly two cycles.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive_px(tv_h[k], tv_v[k], tv_hs[k], tv_hb[k], tv_vs[k], tv_vb[k], tv_rgb[k]);
      tick;
      if (k >= 1) begin
        check($sformatf("lat%0d_hcount", k - 1), bus.hcount_out, tv_h[k-1]);
        check($sformatf("lat%0d_hsync",  k - 1), bus.hsync_out,  tv_hs[k-1]);
        check($sformatf("lat%0d_hblnk",  k - 1), bus.hblnk_out,  tv_hb[k-1]);
        check($sformatf("lat%0d_vcount", k - 1), bus.vcount_out, tv_v[k-1]);
        check($sformatf("lat%0d_vsync",  k - 1), bus.vsync_out,  tv_vs[k-1]);
        check($sformatf("lat%0d_vblnk",  k - 1), bus.vblnk_out,  tv_vb[k-1]);
        check($sformatf("lat%0d_rgb",    k - 1), bus.rgb_out,    tv_exp[k-1]);
      end
    end
    bus.vblnk_in = 1'b0;
    tick;

    // Sample coinciding with the vblnk rising edge takes effect immediately.
    bus.xpos_in   = 12'd10;
    bus.ypos_in   = 12'd20;
    bus.pos_valid = 1'b1;
    bus.vblnk_in  = 1'b1;
    tick;
    bus.pos_valid = 1'b0;
    check("coinc_xpos", bus.xpos_out, 10);
    check("coinc_ypos", bus.ypos_out, 20);
    sample(12'd50, 12'd60);
    check("late_hold_blank", bus.xpos_out, 10);
    bus.vblnk_in = 1'b0;
    tick;
    check("late_hold_active", bus.xpos_out, 10);
    bus.vblnk_in = 1'b1;
    tick;
    check("late_next_frame", bus.xpos_out, 50);
    bus.vblnk_in = 1'b0;
    tick;

    // Asynchronous reset mid-line clears outputs without a clock edge.
    pixel("pre_reset", 11'd20, 11'd30, 12'h789, 12'h789);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    tick;
    rst_n = 1'b1;
    pixel("post_rst_origin", 11'd10, 11'd10, 12'h321, COL);
    check("post_rst_xpos", bus.xpos_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
